// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI-Stream master that emits one packet of incrementing data
// per accepted start request, honours m_ready back-pressure and enforces a
// fixed idle gap before the next packet may be accepted.
//
// state | meaning
// IDLE  | waiting for start with a non-zero length
// SEND  | presenting beats; advances on m_ready
// GAP   | forced idle cycles after the final beat
module axis_pkt_gen #(
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pkt_count
);

  // Gap timer is a down-counter loaded with GAP_CYCLES-1; reaching zero ends GAP.
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    count_q, count_d;

  // State and registered outputs; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // every port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    count_d = count_q;

    case (state_q)
      ST_IDLE: begin
        if (start && (pkt_len != '0)) begin
          state_d = ST_SEND;
          len_d   = pkt_len;
          beat_d  = '0;
          data_d  = seed;
          valid_d = 1'b1;
          last_d  = (pkt_len == LEN_W'(1));
          busy_d  = 1'b1;
        end
      end

      ST_SEND: begin
        // m_valid is always high here, so m_ready alone marks a transfer.
        if (m_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            count_d = count_q + CNT_W'(1);
            if (GAP_CYCLES == 0) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_GAP;
              gap_d   = GAP_W'(GAP_LOAD);
            end
          end else begin
            beat_d = beat_q + LEN_W'(1);
            data_d = data_q + DATA_W'(1);
            last_d = ((beat_q + LEN_W'(1)) == (len_q - LEN_W'(1)));
          end
        end
      end

      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign m_data    = data_q;
  assign m_valid   = valid_q;
  assign m_last    = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pkt_count = count_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Bench for axis_pkt_gen: directed and randomized packets checked against a
// packet-level model (beat i carries seed+i, last on i==len-1, count mod 2^CW).
module tb_axis_pkt_gen;

  localparam int GAP = 2;
  localparam int CW  = 4;

  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic        start   = 1'b0;
  logic [7:0]  pkt_len = 8'd0;
  logic [31:0] seed    = 32'd0;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        busy;
  logic        done;
  logic [CW-1:0] pkt_count;

  int checks    = 0;
  int errors    = 0;
  int exp_count = 0;
  int pat [6]   = '{1, 0, 0, 1, 0, 1};

  axis_pkt_gen #(
    .DATA_W(32), .LEN_W(8), .CNT_W(CW), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pkt_len(pkt_len), .seed(seed),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always high, 1: random ready, 2: fixed pattern 1,0,0,1,0,1
  // poke: pulse start once during SEND and once during GAP
  task automatic run_pkt(input logic [7:0] len, input logic [31:0] sd,
                         input int mode, input bit poke);
    int          ilen, seen, cyc, r;
    logic [31:0] prev_data;
    logic        prev_last, prev_stall;
    ilen = int'(len);
    @(negedge clk);
    start = 1'b1; pkt_len = len; seed = sd; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_busy", 32'(busy), 32'd1);
    chk("first_data", m_data, sd);
    seen = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (seen < ilen && cyc < 20 * ilen + 20) begin
      chk("valid", 32'(m_valid), 32'd1);
      chk("data", m_data, sd + 32'(seen));
      chk("last", 32'(m_last), 32'(seen == ilen - 1));
      chk("busy", 32'(busy), 32'd1);
      chk("done_in_pkt", 32'(done), 32'd0);
      if (prev_stall) begin
        chk("hold_data", m_data, prev_data);
        chk("hold_last", 32'(m_last), 32'(prev_last));
      end
      case (mode)
        0:       r = 1;
        1:       r = ($urandom_range(0, 3) != 0) ? 1 : 0;
        default: r = (cyc < 6) ? pat[cyc] : 1;
      endcase
      m_ready    = (r != 0);
      start      = poke && (cyc == 1);
      prev_stall = !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (m_ready) seen++;
      @(negedge clk);
      cyc++;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    chk("transfers", 32'(seen), 32'(ilen));
    exp_count = (exp_count + 1) % (1 << CW);
    for (int g = 0; g < GAP; g++) begin
      chk("gap_busy", 32'(busy), 32'd1);
      chk("gap_valid", 32'(m_valid), 32'd0);
      chk("gap_last", 32'(m_last), 32'd0);
      chk("gap_done", 32'(done), 32'(g == 0));
      chk("gap_count", 32'(pkt_count), 32'(exp_count));
      start = poke && (g == 0);
      @(negedge clk);
    end
    start = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(m_valid), 32'd0);
    chk("idle_done", 32'(done), 32'(GAP == 0));
    chk("idle_count", 32'(pkt_count), 32'(exp_count));
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_data", m_data, 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(pkt_count), 32'd0);
    reset = 1'b1;

    // basic packet
    run_pkt(8'd4, 32'h100, 0, 1'b0);
    chk("basic_count", 32'(pkt_count), 32'd1);

    // back-pressure pattern
    run_pkt(8'd3, 32'h0, 2, 1'b0);

    // edge lengths and data wrap
    run_pkt(8'd1, 32'hFFFF_FFFF, 0, 1'b0);
    run_pkt(8'd2, 32'hFFFF_FFFF, 0, 1'b0);

    // zero length is ignored
    @(negedge clk);
    start = 1'b1; pkt_len = 8'd0; seed = 32'h55;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("zero_busy", 32'(busy), 32'd0);
      chk("zero_valid", 32'(m_valid), 32'd0);
      @(negedge clk);
    end
    chk("zero_count", 32'(pkt_count), 32'(exp_count));

    // start pulses during SEND and GAP are not queued
    run_pkt(8'd5, 32'h200, 0, 1'b1);
    @(negedge clk);
    chk("poke_no_extra_valid", 32'(m_valid), 32'd0);
    chk("poke_no_extra_busy", 32'(busy), 32'd0);
    chk("poke_count", 32'(pkt_count), 32'(exp_count));

    // randomized packets with random back-pressure
    repeat (4) run_pkt(8'($urandom_range(1, 12)), $urandom, 1, 1'b0);

    // asynchronous reset mid-packet
    @(negedge clk);
    start = 1'b1; pkt_len = 8'd8; seed = 32'hA000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_data", m_data, 32'hA002);
    #2 reset = 1'b0;
    #1;
    chk("arst_data", m_data, 32'd0);
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_last", 32'(m_last), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_count", 32'(pkt_count), 32'd0);
    exp_count = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'(m_valid), 32'd0);
    run_pkt(8'd5, 32'hBEEF_0000, 1, 1'b0);

    // counter wrap: 17 packets from zero leaves the 4-bit count at 1
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_count = 0;
    repeat (17) run_pkt(8'($urandom_range(1, 4)), $urandom, 1, 1'b0);
    chk("wrap_count", 32'(pkt_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
